// File: rtl/uart_loopback_buffered_pkg.sv
// Shared types and helpers for the buffered UART loopback core:
// dispatch FSM states, ASCII bounds and the hex seven-segment glyph table.
package uart_loopback_buffered_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } state_t;

    localparam logic [7:0] ASCII_LC_A = 8'h61;
    localparam logic [7:0] ASCII_LC_Z = 8'h7A;
    localparam logic [7:0] ASCII_CASE = 8'h20;

    // Active-high {A..G}, A at MSB
    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        s = 7'h00;
        unique case (h)
            4'h0: s = 7'h7E;
            4'h1: s = 7'h30;
            4'h2: s = 7'h6D;
            4'h3: s = 7'h79;
            4'h4: s = 7'h33;
            4'h5: s = 7'h5B;
            4'h6: s = 7'h5F;
            4'h7: s = 7'h70;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h7B;
            4'hA: s = 7'h77;
            4'hB: s = 7'h1F;
            4'hC: s = 7'h4E;
            4'hD: s = 7'h3D;
            4'hE: s = 7'h4F;
            4'hF: s = 7'h47;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/uart_loopback_buffered_sync_fifo.sv
// Synchronous FIFO with occupancy level, async active-low reset.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_push,
    input  logic [DATA_W-1:0]          i_data,
    input  logic                       i_pop,
    output logic [DATA_W-1:0]          o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [LW-1:0]     r_level;
    logic              w_push;
    logic              w_pop;

    assign o_full  = (r_level == LW'(DEPTH));
    assign o_empty = (r_level == '0);
    assign o_level = r_level;
    assign o_data  = r_mem[r_rd_ptr];

    // A push into a full FIFO is legal only when a pop frees the slot
    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/uart_loopback_buffered.sv
// Buffered UART RX->TX loopback with hex display and overflow accounting.
// Define UART_LOOPBACK_UPCASE_EN to upper-case ASCII letters on the TX path.
module uart_loopback_buffered
    import uart_loopback_buffered_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int DEPTH      = 16,
    parameter int NUM_DIGITS = DATA_W / 4,
    parameter int DROP_W     = 8
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_rx_valid,
    input  logic [DATA_W-1:0]          i_rx_data,
    input  logic                       i_tx_busy,
    input  logic                       i_hold,
    input  logic                       i_clr_ovf,
    output logic                       o_tx_start,
    output logic [DATA_W-1:0]          o_tx_data,
    output logic [$clog2(DEPTH+1)-1:0] o_fifo_level,
    output logic                       o_overflow,
    output logic [DROP_W-1:0]          o_drop_cnt,
    output logic [7*NUM_DIGITS-1:0]    o_seg
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_wb_seen;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;
    logic              w_full;
    logic              w_empty;
    logic [DATA_W-1:0] w_head;
    logic [DATA_W-1:0] w_tx_nxt;
    logic [DATA_W-1:0] r_tx_data;
    logic              r_overflow;
    logic [DROP_W-1:0] r_drop_cnt;

    assign w_push = i_rx_valid && (!w_full || w_pop);
    assign w_drop = i_rx_valid && !w_push;

    sync_fifo #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .i_push (w_push),
        .i_data (i_rx_data),
        .i_pop  (w_pop),
        .o_data (w_head),
        .o_full (w_full),
        .o_empty(w_empty),
        .o_level(o_fifo_level)
    );

`ifdef UART_LOOPBACK_UPCASE_EN
    logic w_is_lc;
    assign w_is_lc  = (w_head >= DATA_W'(ASCII_LC_A)) &&
                      (w_head <= DATA_W'(ASCII_LC_Z));
    assign w_tx_nxt = w_is_lc ? (w_head - DATA_W'(ASCII_CASE)) : w_head;
`else
    assign w_tx_nxt = w_head;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        o_tx_start  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (!w_empty && !i_hold) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                o_tx_start  = 1'b1;
                w_state_nxt = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (i_tx_busy || r_wb_seen) begin
                    w_state_nxt = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (!i_tx_busy) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // r_wb_seen marks the second WAIT_BUSY cycle, bounding the busy wait
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state   <= S_IDLE;
            r_wb_seen <= 1'b0;
            r_tx_data <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_wb_seen <= (r_state == S_WAIT_BUSY);
            if (w_pop) begin
                r_tx_data <= w_tx_nxt;
            end
        end
    end

    assign o_tx_data = r_tx_data;

    // A drop coinciding with a clear wins and restarts the count at one
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (i_clr_ovf) begin
                r_drop_cnt <= DROP_W'(1);
            end else if (!(&r_drop_cnt)) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
        end else if (i_clr_ovf) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end
    end

    assign o_overflow = r_overflow;
    assign o_drop_cnt = r_drop_cnt;

    for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_digit
        logic [6:0] r_dig;
        always_ff @(posedge i_clk or negedge i_reset) begin
            if (!i_reset) begin
                r_dig <= '1;
            end else if (w_push) begin
                r_dig <= ~hex_to_seg(i_rx_data[4*d +: 4]);
            end
        end
        assign o_seg[7*d +: 7] = r_dig;
    end

endmodule

// File: tb/tb_uart_loopback_buffered.sv
// Self-checking bench for uart_loopback_buffered: queue-based reference
// model compared every cycle, plus directed literal checks.
module tb_uart_loopback_buffered;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_rx_valid = 1'b0;
    logic [7:0]  i_rx_data = 8'h00;
    logic        i_tx_busy = 1'b0;
    logic        i_hold = 1'b0;
    logic        i_clr_ovf = 1'b0;
    logic        o_tx_start;
    logic [7:0]  o_tx_data;
    logic [4:0]  o_fifo_level;
    logic        o_overflow;
    logic [7:0]  o_drop_cnt;
    logic [13:0] o_seg;

    uart_loopback_buffered dut (
        .i_clk       (clk),
        .i_reset     (rst_n),
        .i_rx_valid  (i_rx_valid),
        .i_rx_data   (i_rx_data),
        .i_tx_busy   (i_tx_busy),
        .i_hold      (i_hold),
        .i_clr_ovf   (i_clr_ovf),
        .o_tx_start  (o_tx_start),
        .o_tx_data   (o_tx_data),
        .o_fifo_level(o_fifo_level),
        .o_overflow  (o_overflow),
        .o_drop_cnt  (o_drop_cnt),
        .o_seg       (o_seg)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic logic [6:0] glyph(input logic [3:0] h);
        logic [6:0] t [16];
        t = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
              7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
        return t[h];
    endfunction

    function automatic logic [13:0] segof(input logic [7:0] b);
        return {~glyph(b[7:4]), ~glyph(b[3:0])};
    endfunction

    function automatic logic [7:0] up(input logic [7:0] b);
`ifdef UART_LOOPBACK_UPCASE_EN
        if (b >= 8'h61 && b <= 8'h7A) return b - 8'h20;
`endif
        return b;
    endfunction

    // Reference model: byte queue plus frame timeline flags
    logic [7:0]  q [$];
    bit          m_start, m_wb, m_wd;
    int          m_wbn;
    logic [7:0]  m_tx;
    bit          m_ovf;
    int          m_drop;
    logic [13:0] m_seg;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_start = 0; m_wb = 0; m_wd = 0; m_wbn = 0;
            m_tx = 8'h00; m_ovf = 0; m_drop = 0; m_seg = '1;
        end else begin
            if (m_start) begin
                m_start = 0; m_wb = 1; m_wbn = 0;
            end else if (m_wb) begin
                m_wbn++;
                if (i_tx_busy || m_wbn == 2) begin
                    m_wb = 0; m_wd = 1;
                end
            end else if (m_wd) begin
                if (!i_tx_busy) m_wd = 0;
            end else if (q.size() != 0 && !i_hold) begin
                m_tx = up(q.pop_front());
                m_start = 1;
            end
            if (i_rx_valid && q.size() == DEPTH) begin
                m_ovf = 1;
                m_drop = i_clr_ovf ? 1 : (m_drop < 255 ? m_drop + 1 : 255);
            end else begin
                if (i_rx_valid) begin
                    q.push_back(i_rx_data);
                    m_seg = segof(i_rx_data);
                end
                if (i_clr_ovf) begin
                    m_ovf = 0; m_drop = 0;
                end
            end
        end
    end

    logic [7:0] tx_log [$];
    int         start_cyc [$];

    always @(negedge clk) begin
        if (rst_n) begin
            chk("start", 32'(o_tx_start), 32'(m_start));
            chk("tx_data", 32'(o_tx_data), 32'(m_tx));
            chk("level", 32'(o_fifo_level), 32'(q.size()));
            chk("overflow", 32'(o_overflow), 32'(m_ovf));
            chk("drop_cnt", 32'(o_drop_cnt), 32'(m_drop));
            chk("seg", 32'(o_seg), 32'(m_seg));
            if (o_tx_start) begin
                tx_log.push_back(o_tx_data);
                start_cyc.push_back(cyc);
            end
        end
    end

    // TX emulator: busy rises the cycle after start, lasts busy_len cycles
    int busy_len = 4;
    bit rand_busy = 0;
    int busy_rem = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_rem = 0;
            i_tx_busy = 1'b0;
        end else begin
            if (busy_rem > 0) begin
                i_tx_busy = 1'b1;
                busy_rem--;
            end else begin
                i_tx_busy = 1'b0;
            end
            if (o_tx_start)
                busy_rem = rand_busy ? int'($urandom_range(0, 5)) : busy_len;
        end
    end

    task automatic send(input logic [7:0] b);
        i_rx_valid = 1'b1;
        i_rx_data = b;
        @(negedge clk);
        i_rx_valid = 1'b0;
    endtask

    task automatic wait_starts(input int n, input int budget,
                               input string name);
        int k = 0;
        while (tx_log.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (tx_log.size() < n) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: timeout, got %0d starts expected %0d",
                     name, tx_log.size(), n);
        end
    endtask

    logic [7:0] exp_q [$];
    logic [7:0] t4_in [4];
    logic [7:0] t4_exp [4];
    int base;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_start", 32'(o_tx_start), 32'd0);
        chk("rst_data", 32'(o_tx_data), 32'd0);
        chk("rst_level", 32'(o_fifo_level), 32'd0);
        chk("rst_seg", 32'(o_seg), 32'h3FFF);
        rst_n = 1'b1;
        @(negedge clk);

        // single byte latency and display
        send(8'h3C);
        chk("t1_nostart", 32'(o_tx_start), 32'd0);
        chk("t1_seg", 32'(o_seg), 32'h0331);
        @(negedge clk);
        chk("t1_start", 32'(o_tx_start), 32'd1);
        chk("t1_data", 32'(o_tx_data), 32'h3C);
        repeat (20) @(negedge clk);

        // overflow under hold, then ordered drain
        i_hold = 1'b1;
        exp_q.delete();
        for (int i = 0; i < DEPTH + 3; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            if (i < DEPTH) exp_q.push_back(b);
            send(b);
        end
        chk("t2_level", 32'(o_fifo_level), 32'd16);
        chk("t2_ovf", 32'(o_overflow), 32'd1);
        chk("t2_drop", 32'(o_drop_cnt), 32'd3);
        busy_len = 2;
        base = tx_log.size();
        i_hold = 1'b0;
        wait_starts(base + DEPTH, DEPTH * 8 + 50, "t2_drain");
        for (int i = 0; i < DEPTH; i++)
            if (base + i < tx_log.size())
                chk("t2_order", 32'(tx_log[base+i]), 32'(up(exp_q[i])));
        i_clr_ovf = 1'b1;
        @(negedge clk);
        i_clr_ovf = 1'b0;
        chk("t2_clr_drop", 32'(o_drop_cnt), 32'd0);
        chk("t2_clr_ovf", 32'(o_overflow), 32'd0);
        repeat (10) @(negedge clk);

        // full FIFO with coincident pop and push
        i_hold = 1'b1;
        for (int i = 0; i < DEPTH; i++) send(8'($urandom));
        chk("t3_full", 32'(o_fifo_level), 32'd16);
        i_hold = 1'b0;
        send(8'hA5);
        chk("t3_level", 32'(o_fifo_level), 32'd16);
        chk("t3_nodrop", 32'(o_drop_cnt), 32'd0);
        busy_len = 1;
        base = tx_log.size();
        wait_starts(base + DEPTH + 1, 200, "t3_drain");
        repeat (10) @(negedge clk);

        // case conversion path
        t4_in = '{8'h61, 8'h7A, 8'h7B, 8'h35};
`ifdef UART_LOOPBACK_UPCASE_EN
        t4_exp = '{8'h41, 8'h5A, 8'h7B, 8'h35};
`else
        t4_exp = '{8'h61, 8'h7A, 8'h7B, 8'h35};
`endif
        base = tx_log.size();
        for (int i = 0; i < 4; i++) send(t4_in[i]);
        chk("t4_seg", 32'(o_seg), 32'h0324);
        wait_starts(base + 4, 100, "t4_tx");
        for (int i = 0; i < 4; i++)
            if (base + i < tx_log.size())
                chk("t4_tx", 32'(tx_log[base+i]), 32'(t4_exp[i]));
        repeat (10) @(negedge clk);

        // reset during WAIT_DONE with three queued
        busy_len = 20;
        base = tx_log.size();
        for (int i = 0; i < 4; i++) send(8'h10 + 8'(i));
        wait_starts(base + 1, 20, "t5_first");
        repeat (4) @(negedge clk);
        chk("t5_queued", 32'(o_fifo_level), 32'd3);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_start", 32'(o_tx_start), 32'd0);
        chk("t5_rst_data", 32'(o_tx_data), 32'd0);
        chk("t5_rst_level", 32'(o_fifo_level), 32'd0);
        chk("t5_rst_seg", 32'(o_seg), 32'h3FFF);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        base = tx_log.size();
        repeat (15) @(negedge clk);
        chk("t5_nostart", 32'(tx_log.size()), 32'(base));

        // busy never rises: timeout spacing is five cycles
        busy_len = 0;
        base = tx_log.size();
        for (int i = 0; i < 3; i++) send(8'h20 + 8'(i));
        wait_starts(base + 3, 60, "t6_tx");
        if (tx_log.size() >= base + 3) begin
            chk("t6_gap1", 32'(start_cyc[base+1] - start_cyc[base]), 32'd5);
            chk("t6_gap2", 32'(start_cyc[base+2] - start_cyc[base+1]), 32'd5);
        end
        repeat (10) @(negedge clk);

        // drop counter saturation
        i_hold = 1'b1;
        for (int i = 0; i < 300; i++) send(8'($urandom));
        chk("t7_sat", 32'(o_drop_cnt), 32'd255);
        chk("t7_ovf", 32'(o_overflow), 32'd1);
        i_clr_ovf = 1'b1;
        @(negedge clk);
        i_clr_ovf = 1'b0;
        chk("t7_clr", 32'(o_drop_cnt), 32'd0);
        i_hold = 1'b0;
        base = tx_log.size();
        wait_starts(base + DEPTH, DEPTH * 6 + 50, "t7_drain");

        // randomized traffic, checked by the model every cycle
        rand_busy = 1;
        for (int i = 0; i < 2000; i++) begin
            i_rx_valid = ($urandom_range(0, 2) == 0);
            i_rx_data = 8'($urandom);
            if ($urandom_range(0, 19) == 0) i_hold = ~i_hold;
            i_clr_ovf = ($urandom_range(0, 49) == 0);
            @(negedge clk);
        end
        i_rx_valid = 1'b0;
        i_clr_ovf = 1'b0;
        i_hold = 1'b0;
        repeat (200) @(negedge clk);
        chk("end_level", 32'(o_fifo_level), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
